// File: rtl/drum_step_scheduler_if.sv
// Sample hand-off from the drum timestep scheduler to the audio FIFO.
// The scheduler drives valid/data and the FIFO returns ready.
interface drum_step_scheduler_if;
  logic               sample_valid;
  logic               sample_ready;
  logic signed [17:0] sample_data;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/drum_step_scheduler.sv
// Global timestep scheduler for the drum membrane column array.
// Define DRUM_OVERRUN_CNT_EN to add the saturating overrun_count port.
//
// state | meaning
// IDLE  | after reset, waiting for the first pluck request
// INIT  | columns load the initial membrane condition
// WAIT  | waiting for a sample tick (or a pending one)
// RUN   | columns compute one timestep
// EMIT  | captured centre node offered to the audio path
module drum_step_scheduler #(
  parameter int C          = 30,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shoot,
  input  logic [C-1:0]       col_done,
  input  logic signed [17:0] node_in,
  output logic               col_init,
  output logic               col_start,
  output logic [31:0]        step_count,
  output logic               busy,
  drum_step_scheduler_if.master smp
`ifdef DRUM_OVERRUN_CNT_EN
  ,
  output logic [15:0]        overrun_count
`endif
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_RUN,
    S_EMIT
  } state_t;

  state_t             state, state_n;
  logic [TW-1:0]      tcnt;
  logic               tick;
  logic               shoot_q;
  logic               shoot_rise;
  logic               init_pend;
  logic               tick_pend;
  logic [1:0]         mask;
  logic               done_ok;
  logic               enter_init;
  logic               enter_run;
  logic               capture;
  logic               handshake;
  logic               valid_q;
  logic signed [17:0] data_q;

  assign tick       = (tcnt == TW'(SAMPLE_DIV - 1));
  assign shoot_rise = shoot & ~shoot_q;
  // col_done may still show the previous step for a cycle after a pulse,
  // so it is ignored for the pulse cycle and the one after (INIT and RUN).
  assign done_ok    = (mask == 2'd0) & (&col_done);

  assign smp.sample_valid = valid_q;
  assign smp.sample_data  = data_q;

  always_comb begin
    state_n   = state;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_pend) state_n = S_INIT;
      end
      S_INIT: begin
        if (done_ok) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (init_pend)              state_n = S_INIT;
        else if (tick || tick_pend) state_n = S_RUN;
      end
      S_RUN: begin
        if (done_ok) begin
          capture = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (valid_q && smp.sample_ready) begin
          handshake = 1'b1;
          state_n   = init_pend ? S_INIT : S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
    enter_init = (state_n == S_INIT) && (state != S_INIT);
    enter_run  = (state_n == S_RUN)  && (state != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      shoot_q    <= 1'b0;
      init_pend  <= 1'b0;
      tick_pend  <= 1'b0;
      mask       <= 2'd0;
      col_init   <= 1'b0;
      col_start  <= 1'b0;
      busy       <= 1'b0;
      step_count <= 32'd0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state     <= state_n;
      tcnt      <= tick ? '0 : tcnt + 1'b1;
      shoot_q   <= shoot;
      col_init  <= enter_init;
      col_start <= enter_run;
      busy      <= (state_n == S_INIT) || (state_n == S_RUN);

      // a new request arriving as INIT is entered is kept, not lost
      if (shoot_rise)      init_pend <= 1'b1;
      else if (enter_init) init_pend <= 1'b0;

      if (enter_init || enter_run) mask <= 2'd2;
      else if (mask != 2'd0)       mask <= mask - 2'd1;

      if (enter_init)
        tick_pend <= 1'b0;
      else if ((state == S_WAIT) && (tick || tick_pend))
        tick_pend <= 1'b0;
      else if (((state == S_RUN) || (state == S_EMIT)) && tick)
        tick_pend <= 1'b1;

      if (enter_init)   step_count <= 32'd0;
      else if (capture) step_count <= step_count + 32'd1;

      if (enter_init)     valid_q <= 1'b0;
      else if (capture)   valid_q <= 1'b1;
      else if (handshake) valid_q <= 1'b0;

      if (capture) data_q <= node_in;
    end
  end

`ifdef DRUM_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      overrun_count <= 16'd0;
    else if (((state == S_RUN) || (state == S_EMIT)) && tick && tick_pend &&
             (overrun_count != 16'hFFFF))
      overrun_count <= overrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Self-checking bench for drum_step_scheduler: expected timing is derived from
// the tick arithmetic (tick every DIV cycles since reset) and pending-tick rules.
module tb_drum_step_scheduler;
  localparam int C   = 4;
  localparam int DIV = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               shoot;
  logic [C-1:0]       col_done;
  logic signed [17:0] node_in;
  logic               col_init, col_start, busy;
  logic [31:0]        step_count;
`ifdef DRUM_OVERRUN_CNT_EN
  logic [15:0]        overrun_count;
  int                 exp_ovr;
`endif

  drum_step_scheduler_if smp();

  always #5 clk = ~clk;

  drum_step_scheduler #(.C(C), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .shoot(shoot), .col_done(col_done), .node_in(node_in),
    .col_init(col_init), .col_start(col_start), .step_count(step_count),
    .busy(busy), .smp(smp)
`ifdef DRUM_OVERRUN_CNT_EN
    , .overrun_count(overrun_count)
`endif
  );

  int  n_vec, n_err;
  int  cyc, c0;
  bit  pend;
  int  exp_steps;
  int  cnt[C];
  int  run_lat[C];
  int  init_lat;
  bit  node_fixed;

  function automatic bit is_tick(input int c);
    return ((c - c0) % DIV) == (DIV - 1);
  endfunction

  // Advance one cycle and play the column array / node source.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (col_init === 1'b1 || col_start === 1'b1) begin
      for (int i = 0; i < C; i++) cnt[i] = (col_init === 1'b1) ? init_lat : run_lat[i];
      col_done = '0;
    end else begin
      for (int i = 0; i < C; i++)
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) col_done[i] = 1'b1;
        end
    end
    node_in = node_fixed ? 18'sh1F00 : 18'($urandom);
  endtask

  // Runs nsteps timesteps from the first cycle of WAIT, checking every cycle.
  // mode 0: ready tied high, 1: random ready, 2: ready low for hold cycles after valid.
  task automatic run_timesteps(input int nsteps, input int lat_lo, input int lat_hi,
                               input int mode, input int hold);
    int s, d, h, t, lmax, guard;
    bit pend_run;
    logic signed [17:0] exp_data;
    for (int k = 0; k < nsteps; k++) begin
      lmax = 0;
      for (int i = 0; i < C; i++) begin
        run_lat[i] = $urandom_range(lat_hi, lat_lo);
        if (run_lat[i] > lmax) lmax = run_lat[i];
      end
      if (pend) s = cyc + 1;
      else begin
        t = cyc;
        while (!is_tick(t)) t++;
        s = t + 1;
      end
      d = s + lmax;
      h = -1;
      guard = 0;
      pend_run = 1'b0;
      exp_data = '0;
      while (h < 0 && guard < 400) begin
        guard++;
        n_vec++;
        if (col_start !== (cyc == s)) begin
          n_err++;
          $display("FAIL col_start cyc=%0d got=%b want=%b", cyc, col_start, (cyc == s));
        end
        n_vec++;
        if (busy !== (cyc >= s && cyc <= d)) begin
          n_err++;
          $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (cyc >= s && cyc <= d));
        end
        n_vec++;
        if (smp.sample_valid !== (cyc > d)) begin
          n_err++;
          $display("FAIL sample_valid cyc=%0d got=%b want=%b", cyc, smp.sample_valid, (cyc > d));
        end
        n_vec++;
        if (step_count !== 32'((cyc > d) ? exp_steps + 1 : exp_steps)) begin
          n_err++;
          $display("FAIL step_count cyc=%0d got=%0d want=%0d", cyc, step_count,
                   (cyc > d) ? exp_steps + 1 : exp_steps);
        end
        if (cyc > d) begin
          n_vec++;
          if (smp.sample_data !== exp_data) begin
            n_err++;
            $display("FAIL sample_data cyc=%0d got=%0d want=%0d", cyc, smp.sample_data, exp_data);
          end
        end
`ifdef DRUM_OVERRUN_CNT_EN
        n_vec++;
        if (overrun_count !== 16'(exp_ovr)) begin
          n_err++;
          $display("FAIL overrun_count cyc=%0d got=%0d want=%0d", cyc, overrun_count, exp_ovr);
        end
`endif
        if (cyc == d) exp_data = node_in;
        if (cyc >= s && is_tick(cyc)) begin
          if (pend_run) begin
`ifdef DRUM_OVERRUN_CNT_EN
            if (exp_ovr < 16'hFFFF) exp_ovr++;
`endif
          end else pend_run = 1'b1;
        end
        case (mode)
          0:       smp.sample_ready = 1'b1;
          1:       smp.sample_ready = ($urandom_range(2, 0) == 0) || (cyc > d + 30);
          default: smp.sample_ready = (cyc > d + hold);
        endcase
        if (cyc > d && smp.sample_ready) h = cyc;
        step();
      end
      if (h < 0) begin
        n_vec++;
        n_err++;
        $display("FAIL step_timeout cyc=%0d got=no_handshake want=handshake", cyc);
      end
      exp_steps++;
      pend = pend_run;
    end
    n_vec++;
    if (smp.sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_drop cyc=%0d got=%b want=0", cyc, smp.sample_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if ({col_init, col_start, busy, smp.sample_valid, step_count, smp.sample_data} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b/%0d/%0d want=0", cyc, col_init,
                 col_start, busy, smp.sample_valid, step_count, smp.sample_data);
      end
`ifdef DRUM_OVERRUN_CNT_EN
      n_vec++;
      if (overrun_count !== 16'd0) begin
        n_err++;
        $display("FAIL reset_overrun got=%0d want=0", overrun_count);
      end
`endif
    end
    c0 = cyc;
    rst = 1'b0;
    pend = 1'b0;
    exp_steps = 0;
`ifdef DRUM_OVERRUN_CNT_EN
    exp_ovr = 0;
`endif
  endtask

  task automatic test_init();
    int pulses, guard;
    init_lat = 1;
    shoot = 1'b1;
    step();
    n_vec++;
    if (col_init !== 1'b0) begin
      n_err++;
      $display("FAIL init_early cyc=%0d got=%b want=0", cyc, col_init);
    end
    step();
    n_vec++;
    if ({col_init, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL init_pulse cyc=%0d got=%b%b want=11", cyc, col_init, busy);
    end
    n_vec++;
    if (step_count !== 32'd0) begin
      n_err++;
      $display("FAIL init_step_count got=%0d want=0", step_count);
    end
    shoot = 1'b0;
    pulses = 1;
    guard = 0;
    while (busy === 1'b1 && guard < 50) begin
      step();
      guard++;
      if (col_init === 1'b1) pulses++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_timeout got=busy%b want=busy0", busy);
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL init_pulse_count got=%0d want=1", pulses);
    end
    n_vec++;
    if ({smp.sample_valid, col_start, step_count} !== '0) begin
      n_err++;
      $display("FAIL init_wait_state got=%b%b/%0d want=0", smp.sample_valid, col_start, step_count);
    end
    pend = 1'b0;
    exp_steps = 0;
  endtask

  task automatic test_steady();
    node_fixed = 1'b1;
    run_timesteps(10, 5, 5, 0, 0);
    node_fixed = 1'b0;
    n_vec++;
    if (step_count !== 32'd10) begin
      n_err++;
      $display("FAIL steady_step_count got=%0d want=10", step_count);
    end
  endtask

  task automatic test_back_pressure();
    run_timesteps(3, 5, 5, 2, 20);
  endtask

  task automatic test_overrun();
    run_timesteps(4, 40, 40, 0, 0);
  endtask

  task automatic test_random();
    run_timesteps(30, 2, 12, 1, 0);
  endtask

  task automatic test_deferred_shoot();
    int s, d, t;
    logic signed [17:0] exp_data;
    for (int i = 0; i < C; i++) run_lat[i] = 6;
    if (pend) s = cyc + 1;
    else begin
      t = cyc;
      while (!is_tick(t)) t++;
      s = t + 1;
    end
    d = s + 6;
    exp_data = '0;
    smp.sample_ready = 1'b1;
    while (cyc <= d + 1) begin
      n_vec++;
      if ({col_init, col_start, smp.sample_valid} !== {1'b0, (cyc == s), (cyc > d)}) begin
        n_err++;
        $display("FAIL defer_run cyc=%0d got=%b%b%b want=0%b%b", cyc, col_init, col_start,
                 smp.sample_valid, (cyc == s), (cyc > d));
      end
      if (cyc == d + 1) begin
        n_vec++;
        if (smp.sample_data !== exp_data) begin
          n_err++;
          $display("FAIL defer_data got=%0d want=%0d", smp.sample_data, exp_data);
        end
      end
      if (cyc == d) exp_data = node_in;
      if (cyc == s + 2) shoot = 1'b1;
      step();
    end
    n_vec++;
    if ({col_init, busy, smp.sample_valid} !== 3'b110 || step_count !== 32'd0) begin
      n_err++;
      $display("FAIL defer_init cyc=%0d got=%b%b%b/%0d want=110/0", cyc, col_init, busy,
               smp.sample_valid, step_count);
    end
    shoot = 1'b0;
    init_lat = 3;
    for (int g = 0; g < 50 && busy === 1'b1; g++) step();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL defer_init_timeout got=busy%b want=busy0", busy);
    end
    pend = 1'b0;
    exp_steps = 0;
    run_timesteps(2, 3, 3, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < C; i++) run_lat[i] = 4;
    smp.sample_ready = 1'b0;
    for (int g = 0; g < 60 && smp.sample_valid !== 1'b1; g++) step();
    n_vec++;
    if (smp.sample_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstrun_valid got=%b want=1", smp.sample_valid);
    end
    step();
    step();
    rst = 1'b1;
    step();
    n_vec++;
    if ({smp.sample_valid, busy, col_start, col_init, step_count} !== '0) begin
      n_err++;
      $display("FAIL rstrun_outputs cyc=%0d got=%b%b%b%b/%0d want=0", cyc, smp.sample_valid,
               busy, col_start, col_init, step_count);
    end
`ifdef DRUM_OVERRUN_CNT_EN
    n_vec++;
    if (overrun_count !== 16'd0) begin
      n_err++;
      $display("FAIL rstrun_overrun got=%0d want=0", overrun_count);
    end
    exp_ovr = 0;
`endif
    rst = 1'b0;
    c0 = cyc;
    smp.sample_ready = 1'b1;
    for (int k = 0; k < 3 * DIV; k++) begin
      step();
      n_vec++;
      if ({col_start, col_init, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL rstrun_idle cyc=%0d got=%b%b%b want=000", cyc, col_start, col_init, busy);
      end
    end
    test_init();
    run_timesteps(3, 2, 8, 1, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    c0 = 0;
    init_lat = 1;
    node_fixed = 1'b0;
    shoot = 1'b0;
    col_done = '0;
    node_in = '0;
    smp.sample_ready = 1'b0;
    for (int i = 0; i < C; i++) begin
      cnt[i] = 0;
      run_lat[i] = 2;
    end
    test_reset();
    test_init();
    test_steady();
    test_back_pressure();
    test_overrun();
    test_random();
    test_deferred_shoot();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
